// File: rtl/multi_pwm_if.sv
// Bus bundle for multi_pwm: duty/load/enable in, PWM and interrupt status out.
interface multi_pwm_if #(
   parameter int N_CH = 2,
   parameter int DW   = 10
);
   logic                ce;
   logic [N_CH*DW-1:0]  duty;
   logic                load;
   logic                pending;
   logic [N_CH-1:0]     pwm_s;
   logic                clk_int;
   logic                irq_pulse;

   // Controller side: drives enable, duty requests and load strobe.
   modport master (
      output ce, duty, load,
      input  pending, pwm_s, clk_int, irq_pulse
   );

   // PWM block side.
   modport slave (
      input  ce, duty, load,
      output pending, pwm_s, clk_int, irq_pulse
   );
endinterface

// File: rtl/multi_pwm.sv
// Multi-channel PWM generator with double-buffered duty registers and a
// period-derived interrupt square wave plus start-of-cycle pulse.
module multi_pwm #(
   parameter int N_CH       = 2,
   parameter int DW         = 10,
   parameter int PRESC      = 600,
   parameter int INT_DIV    = 40,
   parameter int INT_HIGH   = 20,
   parameter int INTERLEAVE = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   multi_pwm_if.slave    bus
);

   localparam int PW = $clog2(PRESC);
   localparam int IW = $clog2(INT_DIV);

   localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESC - 1);
   localparam logic [IW-1:0] INT_MAX    = IW'(INT_DIV - 1);
   localparam logic [IW-1:0] INT_HIGH_C = IW'(INT_HIGH);
   localparam logic [DW-1:0] CAR_MAX    = '1;
   // Phase step between adjacent channels when carriers are interleaved.
   localparam logic [DW-1:0] CAR_STEP   = DW'((1 << DW) / N_CH);

   logic [PW-1:0]      presc_q,     presc_d;
   logic [DW-1:0]      carrier_q,   carrier_d;
   logic [IW-1:0]      int_cnt_q,   int_cnt_d;
   logic [N_CH*DW-1:0] shadow_q,    shadow_d;
   logic [N_CH*DW-1:0] active_q,    active_d;
   logic               pending_q,   pending_d;
   logic [N_CH-1:0]    pwm_s_q,     pwm_s_d;
   logic               clk_int_q,   clk_int_d;
   logic               irq_pulse_q, irq_pulse_d;

   logic               tick;
   logic               boundary;
   logic [DW-1:0]      ch_car [N_CH];

   // Per-channel carrier: shared carrier, optionally phase-shifted per channel.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_car[i] = (INTERLEAVE != 0) ? carrier_q + DW'(i) * CAR_STEP : carrier_q;
      end
   end

   // Next-state logic: prescaler, carrier, interrupt counter, duty buffering.
   always_comb begin
      // NOTE: every _d gets a default first so no path through this block
      // leaves it unassigned, which would otherwise infer a latch.
      tick        = bus.ce && (presc_q == PRESC_MAX);
      boundary    = tick && (carrier_q == CAR_MAX);
      presc_d     = presc_q;
      carrier_d   = carrier_q;
      int_cnt_d   = int_cnt_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      pending_d   = pending_q;
      pwm_s_d     = pwm_s_q;
      clk_int_d   = clk_int_q;
      irq_pulse_d = 1'b0;

      if (bus.ce) begin
         presc_d   = tick ? '0 : presc_q + 1'b1;
         clk_int_d = (int_cnt_q < INT_HIGH_C);
         for (int i = 0; i < N_CH; i++) begin
            pwm_s_d[i] = (ch_car[i] < active_q[i*DW +: DW]);
         end
      end

      if (tick) begin
         carrier_d = carrier_q + 1'b1;
      end

      if (boundary) begin
         int_cnt_d   = (int_cnt_q == INT_MAX) ? '0 : int_cnt_q + 1'b1;
         irq_pulse_d = (int_cnt_q == INT_MAX);
         if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
      end

      // A load is honoured regardless of ce; on a boundary it bypasses the
      // shadow so the new duty governs the period that is just starting.
      if (bus.load) begin
         shadow_d = bus.duty;
         if (boundary) begin
            active_d  = bus.duty;
            pending_d = 1'b0;
         end else begin
            pending_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         carrier_q   <= '0;
         int_cnt_q   <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         pending_q   <= 1'b0;
         pwm_s_q     <= '0;
         clk_int_q   <= 1'b0;
         irq_pulse_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         presc_q     <= presc_d;
         carrier_q   <= carrier_d;
         int_cnt_q   <= int_cnt_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pwm_s_q     <= pwm_s_d;
         clk_int_q   <= clk_int_d;
         irq_pulse_q <= irq_pulse_d;
      end
   end

   assign bus.pending   = pending_q;
   assign bus.pwm_s     = pwm_s_q;
   assign bus.clk_int   = clk_int_q;
   assign bus.irq_pulse = irq_pulse_q;

endmodule
